router_fifo: RTL and testbench

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_fifo_if.sv | 25 ++
 rtl/router_fifo.sv | 92 +++++++++
 tb/tb_router_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/router_fifo_if.sv
// Router FIFO bus: write side (push + header flag + byte), read side (pop + registered byte),
// and the full/empty status the sync block and reader watch.
//   master : drives write_enb, read_enb, lfd_state, data_in; observes data_out, full, empty
//   slave  : the FIFO itself
interface router_fifo_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/router_fifo.sv
// Router output FIFO. Stores {header_flag, byte} entries, pops with one cycle of latency
// into a registered data_out, and tracks the remaining length of the packet being read so
// that data_out returns to 0 at packet boundaries when nothing is popped.
//   clock      : single rising-edge clock
//   resetn     : asynchronous active-low reset
//   soft_reset : synchronous flush, overrides push/pop in its cycle
//   bus        : router_fifo_if slave (write_enb, read_enb, lfd_state, data_in,
//                data_out, full, empty)
module router_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic          clock,
  input logic          resetn,
  input logic          soft_reset,
  router_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [5:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH:0]   rd_entry;
  logic             full, empty, push, pop;

  // Extra pointer MSB distinguishes a full ring from an empty one.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push     = bus.write_enb & ~full;
  assign pop      = bus.read_enb & ~empty;
  assign rd_entry = mem[rd_ptr_q[AW-1:0]];

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.data_out = data_out_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        data_out_d = rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH]) begin
          // Header: payload length from bits [7:2], plus one for the parity byte.
          pkt_cnt_d = rd_entry[7:2] + 6'd1;
        end else if (pkt_cnt_q != 6'd0) begin
          pkt_cnt_d = pkt_cnt_q - 6'd1;
        end
      end else if (pkt_cnt_q == 6'd0) begin
        // Between packets the output idles at zero.
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push && !soft_reset) begin
      mem[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic soft_reset = 1'b0;

  router_fifo_if #(.WIDTH(WIDTH)) bus ();

  router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Behavioural model: a queue of {header, byte}, a packet byte countdown and the
  // expected output byte.
  logic [8:0] mq[$];
  logic [5:0] m_cnt = '0;
  logic [7:0] m_dout = '0;
  bit         started = 1'b0;

  always @(posedge clock or negedge resetn) begin
    logic [8:0] e;
    bit do_push, do_pop;
    if (!resetn || soft_reset) begin
      mq.delete();
      m_cnt  = '0;
      m_dout = '0;
    end else begin
      do_push = bus.write_enb && (mq.size() < DEPTH);
      do_pop  = bus.read_enb && (mq.size() > 0);
      if (do_pop) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = e[7:2] + 6'd1;
        else if (m_cnt != 0) m_cnt = m_cnt - 6'd1;
      end else if (m_cnt == 0) begin
        m_dout = '0;
      end
      if (do_push) mq.push_back({bus.lfd_state, bus.data_in});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (resetn && started) begin
      chk("cyc_data_out", {24'd0, bus.data_out}, {24'd0, m_dout});
      chk("cyc_empty", {31'd0, bus.empty}, {31'd0, mq.size() == 0});
      chk("cyc_full", {31'd0, bus.full}, {31'd0, mq.size() == DEPTH});
    end
  end

  task automatic cyc(input logic wr, input logic rd, input logic lfd, input logic [7:0] d);
    bus.write_enb = wr;
    bus.read_enb  = rd;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    @(posedge clock);
    #1;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  initial begin
    logic [7:0] pkt [5];
    pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hB2; pkt[3] = 8'hC3; pkt[4] = 8'hE4;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = '0;

    // Reset state
    #12;
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    resetn  = 1'b1;
    started = 1'b1;
    @(posedge clock);
    #1;

    // Header 0x0D (len 3) + 3 payload + parity, then pop all five
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, (i == 0), pkt[i]);
    chk("pkt_queued", mq.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("pkt_data_out", {24'd0, bus.data_out}, {24'd0, pkt[i]});
      chk("pkt_cnt_model", {26'd0, m_cnt}, 32'(4 - i));
    end
    chk("pkt_empty_after", {31'd0, bus.empty}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("pkt_idle_zero", {24'd0, bus.data_out}, 32'd0);

    // Fill to 16, drop 17th, drain in order
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'hFF);
    chk("drop_full", {31'd0, bus.full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_data", {24'd0, bus.data_out}, 32'(8'h10 + i));
    end
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);

    // Full FIFO: simultaneous push and pop -> pop only
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    cyc(1'b1, 1'b1, 1'b0, 8'h77);
    chk("full_rw_data", {24'd0, bus.data_out}, 32'h20);
    chk("full_rw_notfull", {31'd0, bus.full}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("full_rw_drain", {24'd0, bus.data_out}, 32'(8'h20 + i));
    end
    chk("full_rw_empty", {31'd0, bus.empty}, 32'd1);

    // Empty FIFO: simultaneous push and pop -> push only
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h55);
    chk("empty_rw_data", {24'd0, bus.data_out}, 32'd0);
    chk("empty_rw_notempty", {31'd0, bus.empty}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("empty_rw_pop", {24'd0, bus.data_out}, 32'h55);

    // Soft reset mid-packet with a concurrent write
    cyc(1'b1, 1'b0, 1'b1, 8'h0D);
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("srst_pre_data", {24'd0, bus.data_out}, 32'h31);
    soft_reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h88);
    soft_reset = 1'b0;
    chk("srst_empty", {31'd0, bus.empty}, 32'd1);
    chk("srst_data_out", {24'd0, bus.data_out}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h99);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("srst_next_pop", {24'd0, bus.data_out}, 32'h99);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("srst_cnt_cleared", {24'd0, bus.data_out}, 32'd0);

    // Asynchronous reset between edges mid-packet
    cyc(1'b1, 1'b0, 1'b1, 8'h09);
    cyc(1'b1, 1'b0, 1'b0, 8'h41);
    cyc(1'b1, 1'b0, 1'b0, 8'h42);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("arst_pre_data", {24'd0, bus.data_out}, 32'h09);
    #1 resetn = 1'b0;
    #1;
    chk("arst_empty", {31'd0, bus.empty}, 32'd1);
    chk("arst_full", {31'd0, bus.full}, 32'd0);
    chk("arst_data_out", {24'd0, bus.data_out}, 32'd0);
    #1 resetn = 1'b1;
    @(posedge clock);
    #1;
    cyc(1'b1, 1'b0, 1'b0, 8'h66);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("arst_next_pop", {24'd0, bus.data_out}, 32'h66);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("arst_cnt_cleared", {24'd0, bus.data_out}, 32'd0);

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
